// File: rtl/paralelo_serial_tx_if.sv
// Byte handshake between a data source and the serial transmitter.
interface paralelo_serial_tx_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;

  // Source side: offers a byte and holds it until it sees ready.
  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  // Transmitter side: takes the byte into its holding register.
  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );
endinterface

// File: rtl/paralelo_serial_tx.sv
// Byte-wide to serial transmitter. Sends a burst of comma bytes after
// reset so the receiver can lock, then shifts out buffered data bytes
// MSB first, one bit per clock, with commas filling idle byte slots.
module paralelo_serial_tx #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         SYNC_BYTES = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  paralelo_serial_tx_if.slave tx,
  output logic              data_out,
  output logic              tx_active
);

  localparam logic [3:0] SYNC_N = SYNC_BYTES[3:0];

  typedef enum logic {
    SYNC = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t     state_reg;
  logic [2:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic [7:0] hold_reg;
  logic       hold_full_reg;
  logic [3:0] sync_cnt_reg;

  logic       load;
  logic       enter_data;
  logic       take_hold;
  logic       accept;
  logic [7:0] shift_next;

  // The holding register can take a byte only when empty and out of reset.
  assign tx.ready_out = !hold_full_reg && !reset;
  assign accept       = tx.valid_in && tx.ready_out;

  // Byte-boundary decisions and the next shift register contents.
  always_comb begin
    load       = (bit_cnt_reg == 3'd7);
    enter_data = (state_reg == SYNC) && (sync_cnt_reg == SYNC_N);
    take_hold  = 1'b0;
    shift_next = {shift_reg[6:0], 1'b0};
    if (load) begin
      if ((state_reg == SYNC) && !enter_data) begin
        shift_next = COMMA;
      end else if (hold_full_reg) begin
        shift_next = hold_reg;
        take_hold  = 1'b1;
      end else begin
        shift_next = COMMA;
      end
    end
  end

  // Serializer, holding register and SYNC/DATA sequencing.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_reg     <= SYNC;
      bit_cnt_reg   <= 3'd7;
      shift_reg     <= 8'h00;
      hold_reg      <= 8'h00;
      hold_full_reg <= 1'b0;
      sync_cnt_reg  <= 4'd0;
      data_out      <= 1'b0;
      tx_active     <= 1'b0;
    end else begin
      bit_cnt_reg <= bit_cnt_reg + 3'd1;
      shift_reg   <= shift_next;
      // Output the MSB of the post-edge shift contents so a freshly
      // loaded byte starts on the line right after its load edge.
      data_out    <= shift_next[7];

      if (load) begin
        if (enter_data) begin
          state_reg <= DATA;
          tx_active <= 1'b1;
        end else if (state_reg == SYNC) begin
          sync_cnt_reg <= sync_cnt_reg + 4'd1;
        end
      end

      // An accept needs an empty holding register and a load only
      // drains a full one, so the two never coincide.
      if (take_hold) begin
        hold_full_reg <= 1'b0;
      end else if (accept) begin
        hold_reg      <= tx.data_in;
        hold_full_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx: a byte-slot model predicts
// every output bit, plus literal checks on the documented scenarios.
module tb_paralelo_serial_tx;

  localparam logic [7:0] COMMA      = 8'hBC;
  localparam int         SYNC_BYTES = 4;

  logic clk_32f;
  logic reset;
  logic data_out;
  logic tx_active;

  paralelo_serial_tx_if bus ();

  paralelo_serial_tx #(
    .COMMA      (COMMA),
    .SYNC_BYTES (SYNC_BYTES)
  ) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .tx        (bus.slave),
    .data_out  (data_out),
    .tx_active (tx_active)
  );

  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  // Reference model: edges since reset index byte slots of 8 bits; the
  // first SYNC_BYTES slots are commas, later slots take the held byte or
  // a comma. The holding register is a queue of at most one byte.
  int         m_n;
  logic [7:0] m_cur;
  logic       m_out;
  logic       m_tx;
  logic       m_valid = 1'b0;
  logic [7:0] m_hold[$];

  // Advance the model on every clock edge using the inputs seen there.
  always @(posedge clk_32f) begin : model
    bit acc;
    if (reset) begin
      m_n   = 0;
      m_out = 1'b0;
      m_tx  = 1'b0;
      m_cur = 8'h00;
      m_hold.delete();
      m_valid = 1'b1;
    end else begin
      acc = bus.valid_in && (m_hold.size() == 0);
      if (m_n % 8 == 0) begin
        if (m_n / 8 < SYNC_BYTES) begin
          m_cur = COMMA;
        end else begin
          m_tx = 1'b1;
          if (m_hold.size() > 0) m_cur = m_hold.pop_front();
          else m_cur = COMMA;
        end
      end
      m_out = m_cur[7 - (m_n % 8)];
      if (acc) m_hold.push_back(bus.data_in);
      m_n++;
    end
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic stream  [0:4095];
  logic rdy_log [0:4095];
  logic tx_log  [0:4095];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare DUT against the model on the falling edge and log
  // the line state after the preceding rising edge.
  task automatic step();
    @(negedge clk_32f);
    if (m_valid) begin
      check("data_out",  32'(data_out),      32'(m_out));
      check("tx_active", 32'(tx_active),     32'(m_tx));
      check("ready_out", 32'(bus.ready_out), 32'(!reset && (m_hold.size() == 0)));
    end
    if (!reset && cyc < 4096) begin
      stream[cyc]  = data_out;
      rdy_log[cyc] = bus.ready_out;
      tx_log[cyc]  = tx_active;
      cyc++;
    end
  endtask

  task automatic do_reset(input int n);
    reset        = 1'b1;
    bus.valid_in = 1'b0;
    repeat (n) step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  // Offer a byte and wait (bounded) until it is accepted; valid stays high.
  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    bus.data_in  = b;
    bus.valid_in = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      done = bus.ready_out;
      step();
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: byte %02h not accepted, required accept within 40 cycles", b);
    end else begin
      $display("tx byte %02h accepted at line bit %0d", b, cyc - 1);
    end
  endtask

  function automatic logic [7:0] get_byte(input int k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7 - i] = stream[8 * k + i];
    return r;
  endfunction

  initial begin : driver
    int   hi_cnt;
    int   i3c;
    int   i7e;
    int   n3c;
    int   n7e;
    bit   found;
    int   n55;

    reset        = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;

    // Reset, then 48 bits of idle line: 4 sync commas plus 2 idle commas.
    do_reset(3);
    repeat (48) step();
    for (int k = 0; k < 6; k++) check("sync_comma", 32'(get_byte(k)), 32'h000000BC);
    check("tx_before_E32", 32'(tx_log[31]), 0);
    check("tx_after_E32",  32'(tx_log[32]), 1);

    // Accept 0xA5 at E5, during the sync burst.
    do_reset(3);
    repeat (5) step();
    bus.data_in  = 8'hA5;
    bus.valid_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
    repeat (43) step();
    check("ready_at_E4", 32'(rdy_log[4]), 1);
    hi_cnt = 0;
    for (int i = 5; i < 32; i++) hi_cnt += int'(rdy_log[i]);
    check("ready_low_E5_E31", hi_cnt, 0);
    check("ready_after_E32", 32'(rdy_log[32]), 1);
    check("byte4_A5", 32'(get_byte(4)), 32'h000000A5);
    check("byte5_comma", 32'(get_byte(5)), 32'h000000BC);

    // Back-to-back bytes then backpressure with a changed offer.
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h3C);
    send_byte(8'h7E);
    bus.valid_in = 1'b0;
    repeat (40) step();
    found = 1'b0;
    for (int k = 4; k + 3 < cyc / 8; k++)
      if (get_byte(k) == 8'h01 && get_byte(k + 1) == 8'h02 &&
          get_byte(k + 2) == 8'h03 && get_byte(k + 3) == 8'h04) found = 1'b1;
    check("b2b_contiguous", 32'(found), 1);
    n3c = 0; n7e = 0; i3c = -1; i7e = -1;
    for (int k = 0; k < cyc / 8; k++) begin
      if (get_byte(k) == 8'h3C) begin n3c++; i3c = k; end
      if (get_byte(k) == 8'h7E) begin n7e++; i7e = k; end
    end
    check("count_3C", n3c, 1);
    check("count_7E", n7e, 1);
    check("order_3C_7E", i7e - i3c, 1);

    // Reset mid-byte (bit_cnt=3) with a byte waiting in hold.
    while (((cyc - 1) % 8) != 0) step();
    send_byte(8'h55);
    bus.valid_in = 1'b0;
    while (((cyc - 1) % 8) != 3) step();
    check("hold_full_before_reset", 32'(bus.ready_out), 0);
    reset = 1'b1;
    step();
    check("data_out_after_reset", 32'(data_out), 0);
    do_reset(2);
    repeat (48) step();
    n55 = 0;
    for (int k = 0; k < 6; k++) begin
      check("restart_comma", 32'(get_byte(k)), 32'h000000BC);
      if (get_byte(k) == 8'h55) n55++;
    end
    check("held_byte_dropped", n55, 0);

    // Randomized traffic, including one reset partway through.
    for (int it = 0; it < 300; it++) begin
      if (it == 150) do_reset($urandom_range(1, 4));
      if ($urandom_range(0, 2) != 0) begin
        send_byte(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 1) == 0) bus.valid_in = 1'b0;
      end else begin
        bus.valid_in = 1'b0;
        step();
      end
    end
    bus.valid_in = 1'b0;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
